// File: rtl/sprite_rom_arbiter.sv
// sprite_rom_arbiter
//
// Shares a single combinational sprite colour ROM (SPRITE_W x SPRITE_H pixels,
// 3-bit palette index, linear address y*SPRITE_W + x) among N_REQ pixel
// requesters. One ROM access is granted per cycle using a round-robin pointer.
// Each access runs through two stages:
//   stage 0 : pick a winner, register its grant, ROM address and oob flag
//   stage 1 : ROM output is valid for the registered address; the colour is
//             captured into the response registers together with the id
// so a request visible in cycle T produces gnt in T+1 and rsp_valid in T+2.
//
// Ports:
//   Clk        system clock, rising edge
//   Reset_n    asynchronous active-low reset
//   en         allows new grants; an access already in stage 1 still completes
//   req        per-requester request level, held until granted
//   req_x      packed sprite-local x, requester i at [i*X_W +: X_W]
//   req_y      packed sprite-local y, requester i at [i*Y_W +: Y_W]
//   gnt        one-hot single-cycle grant pulse
//   rom_addr   registered address to the sprite ROM
//   rom_data   colour index from the ROM, combinational from rom_addr
//   rsp_valid  one-cycle response strobe
//   rsp_id     requester index of the response
//   rsp_data   colour index (TRANSPARENT for out-of-bounds requests)
//   rsp_oob    response belonged to an out-of-bounds coordinate

module sprite_rom_arbiter #(
    parameter int         N_REQ       = 4,
    parameter int         ID_W        = 2,
    parameter int         SPRITE_W    = 32,
    parameter int         SPRITE_H    = 51,
    parameter int         ADDR_W      = 19,
    parameter int         X_W         = 5,
    parameter int         Y_W         = 6,
    parameter logic [2:0] TRANSPARENT = 3'h0
) (
    input  logic                   Clk,
    input  logic                   Reset_n,
    input  logic                   en,
    input  logic [N_REQ-1:0]       req,
    input  logic [N_REQ*X_W-1:0]   req_x,
    input  logic [N_REQ*Y_W-1:0]   req_y,
    output logic [N_REQ-1:0]       gnt,
    output logic [ADDR_W-1:0]      rom_addr,
    input  logic [2:0]             rom_data,
    output logic                   rsp_valid,
    output logic [ID_W-1:0]        rsp_id,
    output logic [2:0]             rsp_data,
    output logic                   rsp_oob
);

    logic [ID_W-1:0]   rr_ptr;
    logic              s1_valid;
    logic [ID_W-1:0]   s1_id;
    logic              s1_oob;

    logic [N_REQ-1:0]  eligible;
    logic              win_found;
    logic [ID_W-1:0]   win_id;
    logic [ID_W-1:0]   ptr_next;
    logic [N_REQ-1:0]  gnt_next;
    logic [X_W-1:0]    sel_x;
    logic [Y_W-1:0]    sel_y;
    logic              sel_oob;
    logic [ADDR_W-1:0] sel_addr;
    int                scan_idx;

    // Round-robin search: scan upward from the pointer, wrapping modulo N_REQ.
    // The requester currently holding gnt is excluded so that it has one cycle
    // to drop req or present its next coordinates before being re-arbitrated.
    always_comb begin
        eligible  = req & ~gnt;
        win_found = 1'b0;
        win_id    = '0;
        scan_idx  = 0;
        for (int k = 0; k < N_REQ; k++) begin
            scan_idx = int'(rr_ptr) + k;
            if (scan_idx >= N_REQ) begin
                scan_idx = scan_idx - N_REQ;
            end
            if (en && !win_found && eligible[scan_idx]) begin
                win_found = 1'b1;
                win_id    = ID_W'(scan_idx);
            end
        end
    end

    // Winner's coordinates, bounds check, linear address and next pointer.
    // The address is formed at full ADDR_W width so legal coordinates never
    // truncate; the oob flag is evaluated on the raw (zero-extended) values.
    always_comb begin
        sel_x    = req_x[win_id*X_W +: X_W];
        sel_y    = req_y[win_id*Y_W +: Y_W];
        sel_oob  = (int'(sel_x) >= SPRITE_W) || (int'(sel_y) >= SPRITE_H);
        sel_addr = ADDR_W'(sel_y) * ADDR_W'(SPRITE_W) + ADDR_W'(sel_x);
        if (win_id == ID_W'(N_REQ - 1)) begin
            ptr_next = '0;
        end else begin
            ptr_next = win_id + 1'b1;
        end
        gnt_next         = '0;
        gnt_next[win_id] = win_found;
    end

    // Pipeline registers. Without a winner the pointer and ROM address hold,
    // and an out-of-bounds winner leaves the ROM address untouched so the ROM
    // output stays stable. Stage-1 results move into the response registers
    // every cycle; rsp_valid qualifies them.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            gnt       <= '0;
            rom_addr  <= '0;
            rr_ptr    <= '0;
            s1_valid  <= 1'b0;
            s1_id     <= '0;
            s1_oob    <= 1'b0;
            rsp_valid <= 1'b0;
            rsp_id    <= '0;
            rsp_data  <= '0;
            rsp_oob   <= 1'b0;
        end else begin
            gnt      <= gnt_next;
            s1_valid <= win_found;
            if (win_found) begin
                s1_id  <= win_id;
                s1_oob <= sel_oob;
                rr_ptr <= ptr_next;
                if (!sel_oob) begin
                    rom_addr <= sel_addr;
                end
            end
            rsp_valid <= s1_valid;
            rsp_id    <= s1_id;
            rsp_oob   <= s1_oob;
            rsp_data  <= s1_oob ? TRANSPARENT : rom_data;
        end
    end

endmodule
